// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM read-capture calibration logic:
// phase-detector command codes, detector status codes and sequencer states.
package sdram_pkg;

  localparam logic [3:0] CMD_CLR    = 4'h0;
  localparam logic [3:0] CMD_INC    = 4'h1;
  localparam logic [3:0] CMD_DEC    = 4'h2;
  localparam logic [3:0] CMD_DCMRST = 4'h3;
  localparam logic [3:0] CMD_INC90  = 4'h4;
  localparam logic [3:0] CMD_RST90  = 4'hC;

  localparam logic [1:0] PE_NODATA = 2'd0;
  localparam logic [1:0] PE_LATE   = 2'd1;
  localparam logic [1:0] PE_EARLY  = 2'd2;
  localparam logic [1:0] PE_OK     = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_R90,
    ST_RDCM,
    ST_SETTLE,
    ST_CLR,
    ST_REQ,
    ST_WAITD,
    ST_DLY,
    ST_SAMPLE,
    ST_EVAL,
    ST_CRST,
    ST_CWAIT,
    ST_CSTEP
  } state_e;

endpackage

// File: rtl/sdram_phase_win.sv
// Tracks runs of OK samples across one phase sweep and keeps the longest
// run seen so far (earliest run wins a tie).
module sdram_phase_win
  import sdram_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              sclk0,
  input  logic              rst,
  input  logic              clr,
  input  logic              sample,
  input  logic              ok,
  input  logic [STEP_W-1:0] step,
  output logic              found,
  output logic [STEP_W-1:0] win_first,
  output logic [STEP_W-1:0] win_last
);

  logic              found_q, found_d;
  logic              in_run_q, in_run_d;
  logic [STEP_W-1:0] first_q, first_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic [STEP_W-1:0] run_first_q, run_first_d;
  logic [STEP_W-1:0] run_start;
  logic [STEP_W-1:0] run_len;
  logic [STEP_W-1:0] best_len;

  always_ff @(posedge sclk0 or posedge rst) begin
    if (rst) begin
      found_q     <= 1'b0;
      in_run_q    <= 1'b0;
      first_q     <= '0;
      last_q      <= '0;
      run_first_q <= '0;
    end else begin
      found_q     <= found_d;
      in_run_q    <= in_run_d;
      first_q     <= first_d;
      last_q      <= last_d;
      run_first_q <= run_first_d;
    end
  end

  always_comb begin
    found_d     = found_q;
    in_run_d    = in_run_q;
    first_d     = first_q;
    last_d      = last_q;
    run_first_d = run_first_q;
    // Steps are sampled in order, so a run is contiguous exactly while every sample is OK.
    run_start   = in_run_q ? run_first_q : step;
    run_len     = step - run_start;
    best_len    = last_q - first_q;
    if (clr) begin
      found_d     = 1'b0;
      in_run_d    = 1'b0;
      first_d     = '0;
      last_d      = '0;
      run_first_d = '0;
    end else if (sample) begin
      if (ok) begin
        in_run_d    = 1'b1;
        run_first_d = run_start;
        if (!found_q || (run_len > best_len)) begin
          found_d = 1'b1;
          first_d = run_start;
          last_d  = step;
        end
      end else begin
        in_run_d = 1'b0;
      end
    end
  end

  assign found     = found_q;
  assign win_first = first_q;
  assign win_last  = last_q;

endmodule

// File: rtl/sdram_phase_cal.sv
// DQS read-capture calibration: sweeps the DCM fine phase per phase90 position,
// finds the widest OK window from the phase detector and re-centres the DCM in it.
module sdram_phase_cal
  import sdram_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int MAX_STEPS  = 200,
  parameter int SETTLE     = 32,
  parameter int SAMPLE_DLY = 4,
  parameter int MAX_PH90   = 4
) (
  input  logic              sclk0,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              pre_wcmd,
  output logic [3:0]        wd,
  input  logic [1:0]        ph_err,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic [STEP_W-1:0] win_first,
  output logic [STEP_W-1:0] win_last,
  output logic [1:0]        ph90
);

  localparam int               CNT_W      = $clog2(SETTLE + SAMPLE_DLY + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  DLY_END    = CNT_W'(SAMPLE_DLY - 1);
  localparam logic [1:0]        LAST_PH90  = 2'(MAX_PH90 - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] target_q, target_d;
  logic [1:0]        ph90_q, ph90_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              win_clr, win_sample, found;
  logic [STEP_W:0]   win_sum;

  sdram_phase_win #(
    .STEP_W(STEP_W)
  ) u_win (
    .sclk0    (sclk0),
    .rst      (rst),
    .clr      (win_clr),
    .sample   (win_sample),
    .ok       (ph_err == PE_OK),
    .step     (step_q),
    .found    (found),
    .win_first(win_first),
    .win_last (win_last)
  );

  assign win_sum = {1'b0, win_first} + {1'b0, win_last};

  always_ff @(posedge sclk0 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      target_q <= '0;
      ph90_q   <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      target_q <= target_d;
      ph90_q   <= ph90_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    step_d     = step_q;
    target_d   = target_q;
    ph90_d     = ph90_q;
    done_d     = done_q;
    fail_d     = fail_q;
    pre_wcmd   = 1'b0;
    wd         = CMD_CLR;
    rd_req     = 1'b0;
    win_clr    = 1'b0;
    win_sample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = ST_R90;
        end
      end
      ST_R90: begin
        pre_wcmd = 1'b1;
        wd       = CMD_RST90;
        ph90_d   = '0;
        state_d  = ST_RDCM;
      end
      ST_RDCM: begin
        pre_wcmd = 1'b1;
        wd       = CMD_DCMRST;
        step_d   = '0;
        win_clr  = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_END) state_d = ST_CLR;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_CLR: begin
        pre_wcmd = 1'b1;
        wd       = CMD_CLR;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        rd_req = 1'b1;
        // A done arriving with the ack means the burst already returned.
        if (rd_ack) state_d = rd_done ? ST_DLY : ST_WAITD;
      end
      ST_WAITD: begin
        if (rd_done) state_d = ST_DLY;
      end
      ST_DLY: begin
        if (cnt_q == DLY_END) state_d = ST_SAMPLE;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_SAMPLE: begin
        win_sample = 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = ST_EVAL;
        end else begin
          pre_wcmd = 1'b1;
          wd       = CMD_INC;
          step_d   = step_q + 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_EVAL: begin
        if (found) begin
          target_d = win_sum[STEP_W:1];
          state_d  = ST_CRST;
        end else if (ph90_q == LAST_PH90) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pre_wcmd = 1'b1;
          wd       = CMD_INC90;
          ph90_d   = ph90_q + 1'b1;
          state_d  = ST_RDCM;
        end
      end
      ST_CRST: begin
        pre_wcmd = 1'b1;
        wd       = CMD_DCMRST;
        step_d   = '0;  // step counter reused as the centring increment count
        state_d  = ST_CWAIT;
      end
      ST_CWAIT: begin
        if (cnt_q == SETTLE_END) state_d = ST_CSTEP;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_CSTEP: begin
        if (step_q < target_q) begin
          pre_wcmd = 1'b1;
          wd       = CMD_INC;
          step_d   = step_q + 1'b1;
          state_d  = ST_CWAIT;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign fail = fail_q;
  assign ph90 = ph90_q;

endmodule

// File: tb/tb_sdram_phase_cal.sv
// Scoreboarded bench: a detector/memory model answers reads from a per-phase90 OK map,
// a plain-scan reference predicts each calibration, and a monitor checks on completion.
module tb_sdram_phase_cal;
  import sdram_pkg::*;

  localparam int STEP_W     = 8;
  localparam int MAX_STEPS  = 200;
  localparam int SETTLE     = 4;
  localparam int SAMPLE_DLY = 4;
  localparam int MAX_PH90   = 4;
  localparam int BUDGET     = 20000;

  logic              sclk0 = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, fail, pre_wcmd, rd_req;
  logic              rd_ack = 1'b0;
  logic              rd_done = 1'b0;
  logic [3:0]        wd;
  logic [1:0]        ph_err = 2'd0;
  logic [STEP_W-1:0] win_first, win_last;
  logic [1:0]        ph90;

  always #5 sclk0 = ~sclk0;

  sdram_phase_cal #(
    .STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS), .SETTLE(SETTLE),
    .SAMPLE_DLY(SAMPLE_DLY), .MAX_PH90(MAX_PH90)
  ) dut (
    .sclk0(sclk0), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .pre_wcmd(pre_wcmd), .wd(wd), .ph_err(ph_err), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_done(rd_done), .win_first(win_first), .win_last(win_last), .ph90(ph90)
  );

  typedef struct {
    bit ok_end;
    bit bad_end;
    int first;
    int last;
    int target;
    int ph;
    int sweeps;
  } exp_t;

  exp_t exp_q[$];
  bit   ok_map[MAX_PH90][MAX_STEPS];
  int   compared = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_map();
    for (int p = 0; p < MAX_PH90; p++)
      for (int s = 0; s < MAX_STEPS; s++) ok_map[p][s] = 1'b0;
  endtask

  task automatic set_run(input int p, input int a, input int b);
    for (int s = a; s <= b; s++) ok_map[p][s] = 1'b1;
  endtask

  // Reference: scan each phase90 map for maximal OK runs; longest wins, earliest on a tie.
  function automatic exp_t predict();
    exp_t e;
    int   bf, bl, s0;
    bit   okb;
    e = '{default: 0};
    for (int p = 0; p < MAX_PH90; p++) begin
      bf = -1; bl = -1; s0 = -1;
      for (int s = 0; s <= MAX_STEPS; s++) begin
        okb = (s < MAX_STEPS) && ok_map[p][s];
        if (okb && s0 < 0) s0 = s;
        if (!okb && s0 >= 0) begin
          if (bf < 0 || (s - 1 - s0) > (bl - bf)) begin
            bf = s0;
            bl = s - 1;
          end
          s0 = -1;
        end
      end
      if (bf >= 0) begin
        e.ok_end = 1; e.first = bf; e.last = bl; e.target = (bf + bl) / 2;
        e.ph = p; e.sweeps = p + 1;
        return e;
      end
    end
    e.bad_end = 1; e.ph = MAX_PH90 - 1; e.sweeps = MAX_PH90;
    return e;
  endfunction

  // Phase detector + memory controller model
  int dcm_pos = 0, det_p90 = 0, mem_st = 0, ack_dly = 0, done_dly = 0;
  int force_ack = -1, req_drops = 0;

  function automatic logic [1:0] pe_status();
    if (dcm_pos >= 0 && dcm_pos < MAX_STEPS && ok_map[det_p90][dcm_pos]) return PE_OK;
    return 2'($urandom_range(0, 2));
  endfunction

  initial forever begin
    @(negedge sclk0);
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    if (pre_wcmd) begin
      case (wd)
        CMD_INC:    dcm_pos++;
        CMD_DEC:    dcm_pos--;
        CMD_DCMRST: dcm_pos = 0;
        CMD_INC90:  det_p90 = (det_p90 + 1) % 4;
        CMD_RST90:  det_p90 = 0;
        CMD_CLR:    ph_err = PE_NODATA;
        default: ;
      endcase
    end
    if (rst) begin
      mem_st = 0;
    end else if (mem_st == 2) begin
      if (done_dly == 0) begin
        rd_done = 1'b1; ph_err = pe_status(); mem_st = 0;
      end else done_dly--;
    end else begin
      if (mem_st == 0 && rd_req) begin
        ack_dly   = (force_ack >= 0) ? force_ack : int'($urandom_range(0, 3));
        force_ack = -1;
        mem_st    = 1;
      end
      if (mem_st == 1) begin
        if (!rd_req) req_drops++;
        if (ack_dly == 0) begin
          rd_ack = 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            rd_done = 1'b1; ph_err = pe_status(); mem_st = 0;
          end else begin
            done_dly = $urandom_range(0, 3); mem_st = 2;
          end
        end else ack_dly--;
      end
    end
  end

  // Monitor: tallies commands and reads per run, checks against scoreboard when busy falls
  int n_rst90, n_inc90, n_dcmrst, n_inc, n_inc_ctr, n_reads;
  bit busy_prev = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge sclk0); #1;
      if (rst) begin
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) begin
          n_rst90 = 0; n_inc90 = 0; n_dcmrst = 0; n_inc = 0; n_inc_ctr = 0; n_reads = 0;
        end
        if (pre_wcmd) begin
          if (wd == CMD_RST90) n_rst90++;
          if (wd == CMD_INC90) n_inc90++;
          if (wd == CMD_DCMRST) begin n_dcmrst++; n_inc_ctr = 0; end
          if (wd == CMD_INC) begin n_inc++; n_inc_ctr++; end
        end
        if (rd_ack) n_reads++;
        if (!busy && busy_prev) begin
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_end: run ended with done=%0d fail=%0d, required no run", done, fail);
          end else begin
            e = exp_q.pop_front();
            $display("run end: done=%0d fail=%0d win=%0d..%0d ph90=%0d reads=%0d inc=%0d centre_inc=%0d",
                     done, fail, win_first, win_last, ph90, n_reads, n_inc, n_inc_ctr);
            check("done", done, e.ok_end);
            check("fail", fail, e.bad_end);
            check("ph90", ph90, e.ph);
            check("rst90_cmds", n_rst90, 1);
            check("inc90_cmds", n_inc90, e.sweeps - 1);
            check("read_bursts", n_reads, e.sweeps * MAX_STEPS);
            check("dcmrst_cmds", n_dcmrst, e.sweeps + e.ok_end);
            check("inc_cmds", n_inc, e.sweeps * (MAX_STEPS - 1) + (e.ok_end ? e.target : 0));
            if (e.ok_end) begin
              check("win_first", win_first, e.first);
              check("win_last", win_last, e.last);
              check("centre_inc_cmds", n_inc_ctr, e.target);
            end
          end
        end
        busy_prev = busy;
      end
    end
  end

  task automatic run_case(input string name, input int poke);
    bit hung;
    exp_q.push_back(predict());
    @(posedge sclk0); #1 start = 1'b1;
    @(posedge sclk0); #1 start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_done_cleared"}, done, 0);
    check({name, "_fail_cleared"}, fail, 0);
    hung = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge sclk0); #1;
      start = (c == poke);
      if (!busy) begin hung = 1'b0; break; end
    end
    start = 1'b0;
    if (hung) begin
      compared++; mismatched++;
      $display("FAIL %s_hang: busy still 1 after %0d cycles, required 0", name, BUDGET);
      rst = 1'b1; #3 rst = 1'b0;
      exp_q.delete();
    end
    repeat (2) @(posedge sclk0);
    #2 check({name, "_scoreboard_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    clear_map();
    #12;
    check("reset_outputs", {busy, done, fail, pre_wcmd, wd, rd_req, win_first, win_last, ph90}, 0);
    @(posedge sclk0); #3 rst = 1'b0;

    // window in the middle, first read acked after 17 cycles
    clear_map(); set_run(0, 40, 80);
    req_drops = 0; force_ack = 17;
    run_case("mid", -1);
    check("slow_ack_req_held", req_drops, 0);

    // two runs, with a start pulse while busy
    clear_map(); set_run(0, 10, 14); set_run(0, 100, 130);
    run_case("two_runs", 150);

    clear_map(); set_run(0, 199, 199);
    run_case("last_step", -1);

    clear_map(); set_run(0, 20, 29); set_run(0, 60, 69);
    run_case("tie", -1);

    clear_map(); set_run(2, 5, 9);
    run_case("ph90_2", -1);

    clear_map();
    run_case("no_ok", -1);

    // reset mid-sweep after a window has been found
    clear_map(); set_run(0, 10, 20);
    @(posedge sclk0); #1 start = 1'b1;
    @(posedge sclk0); #1 start = 1'b0;
    repeat (600) @(posedge sclk0);
    #3;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_win_last", win_last, 20);
    rst = 1'b1; #1;
    check("mid_rst_outputs", {busy, done, fail, pre_wcmd, wd, rd_req, win_first, win_last, ph90}, 0);
    @(posedge sclk0); #3 rst = 1'b0;

    clear_map(); set_run(0, 40, 80);
    run_case("after_rst", -1);

    for (int k = 0; k < 2; k++) begin
      int a, len;
      clear_map();
      for (int p = 0; p < MAX_PH90; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
            a   = $urandom_range(0, MAX_STEPS - 1);
            len = $urandom_range(0, 30);
            set_run(p, a, (a + len > MAX_STEPS - 1) ? MAX_STEPS - 1 : a + len);
          end
        end
      end
      run_case("random", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_phase_cal.md
Name: sdram_phase_cal

Overview:
- Automatic read-capture calibration sequencer for the SDRAM DQS phase detector / DCM fine-phase controller.
- Drives that block's command interface (pre_wcmd, wd[3:0]) and sweeps the DCM fine phase across the quarter-period selected by phase90sel.
- At each step it obtains a read burst from the memory controller and samples ph_err, then records the window where ph_err==3 (OK).
- At the end it re-centres the DCM phase in that window. If no window exists, it advances phase90sel and retries.

Parameters:
- STEP_W, 8, width of step counters and window registers.
- MAX_STEPS, 200, DCM increments per sweep (must be < 2^STEP_W).
- SETTLE, 32, sclk0 cycles waited after any DCM reset or inc/dec command.
- SAMPLE_DLY, 4, cycles after rd_done before ph_err is sampled.
- MAX_PH90, 4, number of phase90sel positions tried before failing.

Ports:
- sclk0  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; starts calibration; ignored while busy.
- busy  out  1  high from the cycle after start until done/fail is asserted.
- done  out  1  sticky; calibration succeeded; cleared by start or rst.
- fail  out  1  sticky; no OK window in any phase90 position; cleared by start or rst.
- pre_wcmd  out  1  1-cycle command strobe to the phase detector.
- wd  out  4  command code, valid with pre_wcmd: 0 clear status, 1 inc, 2 dec, 3 DCM reset, 4 inc phase90, C reset phase90.
- ph_err  in  2  detector status: 0 no data, 1 late, 2 early, 3 OK.
- rd_req  out  1  read-burst request to the memory controller; held until rd_ack.
- rd_ack  in  1  1-cycle acknowledge; burst is scheduled.
- rd_done  in  1  1-cycle pulse; burst read data has returned.
- win_first  out  STEP_W  first OK step index of the final window.
- win_last  out  STEP_W  last OK step index of the final window.
- ph90  out  2  phase90 position currently in use, mirrored internally.

Behaviour:
- Reset values: FSM IDLE; busy, done, fail, pre_wcmd, rd_req = 0; wd=0; win_first=0; win_last=0; ph90=0.
- Every command is exactly one cycle of pre_wcmd with wd stable in that cycle; wd returns to 0 otherwise. The detector latches on the following negedge, which gives half a cycle of margin.
- States and transitions:
  - IDLE: on start, clear done/fail and go to R90.
  - R90: issue C; ph90=0; go to RDCM.
  - RDCM: issue 3; step=0; clear found; go to SETTLE.
  - SETTLE: count SETTLE cycles, then go to CLR.
  - CLR: issue 0 (status clear); go to REQ.
  - REQ: hold rd_req=1; on rd_ack, drop rd_req in the next cycle and go to WAITD.
  - WAITD: on rd_done go to DLY.
  - DLY: count SAMPLE_DLY, then go to SAMPLE.
  - SAMPLE (1 cycle), on ph_err==3:
    - if !found: win_first=step, win_last=step, found=1;
    - else if step==win_last+1: win_last=step;
    - else (a new run): keep whichever run is longer; on a tie, keep the earlier run.
  - SAMPLE, on any other ph_err: no window update. Value 0 counts as not-OK.
  - After SAMPLE: if step==MAX_STEPS-1 go to EVAL; otherwise issue 1, step++, and go to SETTLE.
  - EVAL:
    - If found: target=(win_first+win_last)>>1 (truncating, width STEP_W+1 internally); go to CRST.
    - Else if ph90==MAX_PH90-1: set fail and go to IDLE.
    - Else: issue 4, ph90++ (wraps mod 4), and go to RDCM.
  - CRST: issue 3; count=0; wait SETTLE, then go to CSTEP.
  - CSTEP: while count<target, issue 1, count++, wait SETTLE. When count==target, set done and go to IDLE.
- Boundary conditions:
  - An OK run that extends to MAX_STEPS-1 is closed at the sweep end.
  - A single-step window gives target=win_first.
  - target=0 skips increments entirely.
- rd_ack and rd_done arriving in the same cycle while in REQ: treat as ack followed by done and go directly to DLY.
- rd_done seen outside WAITD is ignored.
- start while busy is ignored.
- rst at any time aborts immediately: rd_req drops asynchronously and no further commands are issued. The DCM is left where it was; the next start re-resets it.
- No timeout on rd_ack/rd_done. The memory controller guarantees service; the verification environment must include a hang check.

Decomposition:
- Shared package sdram_pkg:
  - command code constants CMD_CLR=0, CMD_INC=1, CMD_DEC=2, CMD_DCMRST=3, CMD_INC90=4, CMD_RST90=C;
  - ph_err code constants PE_NODATA/PE_LATE/PE_EARLY/PE_OK;
  - FSM state encoding.
- One natural sub-module: sdram_phase_win, which tracks and compares OK runs. Inputs are step, ok, and sample strobe; outputs are found, win_first, and win_last.

Test Plan:
- Window in the middle: model returns OK for steps 40..80 with ph90=0 -> win_first=40, win_last=80, then exactly one CMD_DCMRST and 60 CMD_INC pulses in the centre phase, done=1, fail=0.
- Two runs, 10..14 and 100..130 -> final window 100..130, 115 INC pulses in the centre phase.
- OK only at step MAX_STEPS-1 (199) -> win_first=win_last=199, 199 INC pulses, done.
- No OK at ph90=0 and ph90=1, window 5..9 at ph90=2 -> two CMD_INC90 pulses, ph90=2, 7 INC pulses, done.
- ph_err never 3 (alternating 1/2/0) -> three CMD_INC90 pulses and four full sweeps, fail=1, done=0, busy=0.
- Request/handshake robustness and reset:
  - rd_ack delayed 17 cycles -> rd_req stays high throughout.
  - rd_ack and rd_done in the same cycle -> accepted.
  - start pulsed while busy -> ignored.
  - rst asserted mid-sweep -> all outputs return to reset values in the same cycle; a new start runs cleanly.
